// File: rtl/card_mem_arbiter_if.sv
// Bus between the card memory arbiter, its three requesters and the single-port card RAM.
// slave = arbiter view, master = requester/RAM side view.
interface card_mem_arbiter_if #(
   parameter int unsigned ADDR_W  = 5,
   parameter int unsigned STATE_W = 2,
   parameter int unsigned COLOR_W = 12
);
   logic               fsm_wr_en;
   logic [ADDR_W-1:0]  fsm_wr_addr;
   logic [STATE_W-1:0] fsm_wr_state;
   logic               init_req;
   logic [ADDR_W-1:0]  init_addr;
   logic [STATE_W-1:0] init_state;
   logic [COLOR_W-1:0] init_color;
   logic               init_gnt;
   logic               rd_req;
   logic [ADDR_W-1:0]  rd_addr;
   logic               rd_gnt;
   logic               rd_valid;
   logic [STATE_W-1:0] rd_state;
   logic [COLOR_W-1:0] rd_color;
   logic               mem_ready;
   logic               mem_we;
   logic               mem_we_color;
   logic [ADDR_W-1:0]  mem_addr;
   logic [STATE_W-1:0] mem_wstate;
   logic [COLOR_W-1:0] mem_wcolor;
   logic [STATE_W-1:0] mem_rstate;
   logic [COLOR_W-1:0] mem_rcolor;
   logic               fifo_ovf;

   modport slave (
      input  fsm_wr_en, fsm_wr_addr, fsm_wr_state,
             init_req, init_addr, init_state, init_color,
             rd_req, rd_addr, mem_ready, mem_rstate, mem_rcolor,
      output init_gnt, rd_gnt, rd_valid, rd_state, rd_color,
             mem_we, mem_we_color, mem_addr, mem_wstate, mem_wcolor, fifo_ovf
   );

   modport master (
      output fsm_wr_en, fsm_wr_addr, fsm_wr_state,
             init_req, init_addr, init_state, init_color,
             rd_req, rd_addr, mem_ready, mem_rstate, mem_rcolor,
      input  init_gnt, rd_gnt, rd_valid, rd_state, rd_color,
             mem_we, mem_we_color, mem_addr, mem_wstate, mem_wcolor, fifo_ovf
   );
endinterface

// File: rtl/card_mem_arbiter.sv
// Arbitrates the single-port card RAM between game writes (buffered), colour-init beats and reads.
// One memory operation per clock; starved reads are promoted above init after RD_MAX_WAIT denials.
module card_mem_arbiter #(
   parameter int unsigned ADDR_W      = 5,
   parameter int unsigned STATE_W     = 2,
   parameter int unsigned COLOR_W     = 12,
   parameter int unsigned FIFO_DEPTH  = 2,
   parameter int unsigned RD_MAX_WAIT = 8
) (
   input logic               clk,
   input logic               rst,
   card_mem_arbiter_if.slave bus
);
   localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned OCC_W  = PTR_W + 1;
   localparam int unsigned WAIT_W = $clog2(RD_MAX_WAIT + 1);

   typedef enum logic [1:0] {IDLE, WR_FIFO, WR_INIT, RD_ISSUE} arb_state_t;

   typedef struct packed {
      logic [ADDR_W-1:0]  addr;
      logic [STATE_W-1:0] state;
   } game_wr_t;

   arb_state_t         state_q, state_d;
   game_wr_t           fifo_q [FIFO_DEPTH];
   game_wr_t           fifo_head;
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [OCC_W-1:0]   occ_q;
   logic [WAIT_W-1:0]  wait_q;
   logic               fifo_empty_c, fifo_full_c, fifo_push_c, fifo_pop_c;
   logic               init_gnt_c, rd_gnt_c;
   logic               ovf_q, rd_valid_q;
   logic               mem_we_q, mem_we_color_q;
   logic [ADDR_W-1:0]  mem_addr_q;
   logic [STATE_W-1:0] mem_wstate_q;
   logic [COLOR_W-1:0] mem_wcolor_q;

   assign fifo_head    = fifo_q[rd_ptr_q];
   assign fifo_empty_c = (occ_q == '0);
   assign fifo_full_c  = (occ_q == OCC_W'(FIFO_DEPTH));
   assign fifo_push_c  = bus.fsm_wr_en && !rst && (!fifo_full_c || fifo_pop_c);

   // Grant selection: buffered game writes, then starved read, then init, then read.
   always_comb begin
      state_d    = IDLE;
      fifo_pop_c = 1'b0;
      init_gnt_c = 1'b0;
      rd_gnt_c   = 1'b0;
      if (!rst && bus.mem_ready) begin
         if (!fifo_empty_c) begin
            state_d    = WR_FIFO;
            fifo_pop_c = 1'b1;
         end else if (bus.rd_req && (wait_q == WAIT_W'(RD_MAX_WAIT))) begin
            state_d  = RD_ISSUE;
            rd_gnt_c = 1'b1;
         end else if (bus.init_req) begin
            state_d    = WR_INIT;
            init_gnt_c = 1'b1;
         end else if (bus.rd_req) begin
            state_d  = RD_ISSUE;
            rd_gnt_c = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (fifo_push_c) begin
            fifo_q[wr_ptr_q] <= game_wr_t'{addr: bus.fsm_wr_addr, state: bus.fsm_wr_state};
            wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
         end
         if (fifo_pop_c) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         occ_q <= occ_q + OCC_W'(fifo_push_c) - OCC_W'(fifo_pop_c);
         if (bus.fsm_wr_en && !fifo_push_c) begin
            ovf_q <= 1'b1;
         end
      end
   end

   // Registered RAM command for the operation granted this cycle; reads return two cycles after grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         rd_valid_q     <= 1'b0;
         wait_q         <= '0;
         mem_we_q       <= 1'b0;
         mem_we_color_q <= 1'b0;
         mem_addr_q     <= '0;
         mem_wstate_q   <= '0;
         mem_wcolor_q   <= '0;
      end else begin
         state_q        <= state_d;
         rd_valid_q     <= (state_q == RD_ISSUE);
         mem_we_q       <= (state_d == WR_FIFO) || (state_d == WR_INIT);
         mem_we_color_q <= (state_d == WR_INIT);
         case (state_d)
            WR_FIFO: begin
               mem_addr_q   <= fifo_head.addr;
               mem_wstate_q <= fifo_head.state;
               mem_wcolor_q <= '0;
            end
            WR_INIT: begin
               mem_addr_q   <= bus.init_addr;
               mem_wstate_q <= bus.init_state;
               mem_wcolor_q <= bus.init_color;
            end
            RD_ISSUE: begin
               mem_addr_q   <= bus.rd_addr;
               mem_wstate_q <= '0;
               mem_wcolor_q <= '0;
            end
            default: begin
               mem_addr_q   <= '0;
               mem_wstate_q <= '0;
               mem_wcolor_q <= '0;
            end
         endcase
         if (rd_gnt_c) begin
            wait_q <= '0;
         end else if (bus.rd_req && (wait_q != WAIT_W'(RD_MAX_WAIT))) begin
            wait_q <= wait_q + WAIT_W'(1);
         end
      end
   end

   assign bus.init_gnt     = init_gnt_c;
   assign bus.rd_gnt       = rd_gnt_c;
   assign bus.rd_valid     = rd_valid_q;
   assign bus.rd_state     = rd_valid_q ? bus.mem_rstate : '0;
   assign bus.rd_color     = rd_valid_q ? bus.mem_rcolor : '0;
   assign bus.mem_we       = mem_we_q;
   assign bus.mem_we_color = mem_we_color_q;
   assign bus.mem_addr     = mem_addr_q;
   assign bus.mem_wstate   = mem_wstate_q;
   assign bus.mem_wcolor   = mem_wcolor_q;
   assign bus.fifo_ovf     = ovf_q;
endmodule

// File: tb/tb_card_mem_arbiter.sv
// Scoreboard bench for card_mem_arbiter: stimulus queues expected RAM writes and read returns,
// a negedge monitor pops and compares them when the DUT presents mem_we or rd_valid.
module tb_card_mem_arbiter;
   localparam int unsigned ADDR_W  = 5;
   localparam int unsigned STATE_W = 2;
   localparam int unsigned COLOR_W = 12;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   card_mem_arbiter_if #(.ADDR_W(ADDR_W), .STATE_W(STATE_W), .COLOR_W(COLOR_W)) bus ();

   card_mem_arbiter #(
      .ADDR_W(ADDR_W), .STATE_W(STATE_W), .COLOR_W(COLOR_W),
      .FIFO_DEPTH(2), .RD_MAX_WAIT(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      int                 cyc;
      logic [ADDR_W-1:0]  addr;
      logic [STATE_W-1:0] st;
      logic [COLOR_W-1:0] col;
      logic               wc;
   } wr_exp_t;

   typedef struct {
      int                 cyc;
      logic [STATE_W-1:0] st;
      logic [COLOR_W-1:0] col;
   } rd_exp_t;

   wr_exp_t wq[$];
   rd_exp_t rq[$];
   wr_exp_t we_e;
   rd_exp_t rd_e;

   logic [STATE_W-1:0] sh_st  [32];
   logic [COLOR_W-1:0] sh_col [32];
   logic [STATE_W-1:0] ram_st [32];
   logic [COLOR_W-1:0] ram_col[32];

   // Write-first RAM with one-cycle read latency.
   always @(posedge clk) begin
      if (bus.mem_we) begin
         ram_st[bus.mem_addr] <= bus.mem_wstate;
         if (bus.mem_we_color) ram_col[bus.mem_addr] <= bus.mem_wcolor;
      end
      bus.mem_rstate <= bus.mem_we ? bus.mem_wstate : ram_st[bus.mem_addr];
      bus.mem_rcolor <= (bus.mem_we && bus.mem_we_color) ? bus.mem_wcolor : ram_col[bus.mem_addr];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [COLOR_W-1:0] col_of(input int a);
      return COLOR_W'(a * 37 + 5);
   endfunction

   task automatic exp_wr(input int a, input logic [STATE_W-1:0] st,
                         input logic [COLOR_W-1:0] col, input logic wc, input int dly);
      wr_exp_t e;
      e.cyc  = cyc + dly;
      e.addr = ADDR_W'(a);
      e.st   = st;
      e.col  = col;
      e.wc   = wc;
      wq.push_back(e);
      sh_st[a] = st;
      if (wc) sh_col[a] = col;
   endtask

   task automatic exp_rd(input int a);
      rd_exp_t e;
      e.cyc = cyc + 2;
      e.st  = sh_st[a];
      e.col = sh_col[a];
      rq.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare every RAM write and read return against the scoreboard.
   always @(negedge clk) begin
      while (wq.size() > 0 && wq[0].cyc < cyc) begin
         chk("we_missing", 32'(cyc), 32'(wq[0].cyc));
         wq.delete(0);
      end
      while (rq.size() > 0 && rq[0].cyc < cyc) begin
         chk("rd_missing", 32'(cyc), 32'(rq[0].cyc));
         rq.delete(0);
      end
      if (bus.mem_we === 1'b1) begin
         if (wq.size() == 0) begin
            chk("we_unexpected", 32'(bus.mem_we), 32'(0));
         end else begin
            we_e = wq.pop_front();
            chk("we_cycle", 32'(cyc), 32'(we_e.cyc));
            chk("we_addr", 32'(bus.mem_addr), 32'(we_e.addr));
            chk("we_state", 32'(bus.mem_wstate), 32'(we_e.st));
            chk("we_color_en", 32'(bus.mem_we_color), 32'(we_e.wc));
            if (we_e.wc) chk("we_color", 32'(bus.mem_wcolor), 32'(we_e.col));
         end
      end
      if (bus.rd_valid === 1'b1) begin
         if (rq.size() == 0) begin
            chk("rd_unexpected", 32'(bus.rd_valid), 32'(0));
         end else begin
            rd_e = rq.pop_front();
            chk("rd_cycle", 32'(cyc), 32'(rd_e.cyc));
            chk("rd_state", 32'(bus.rd_state), 32'(rd_e.st));
            chk("rd_color", 32'(bus.rd_color), 32'(rd_e.col));
         end
      end
   end

   // Init burst; optional back-to-back game pulses at loop cycle fsm_k stall init for two cycles.
   task automatic init_burst(input int first, input int nbeats, input int fsm_k,
                             input int a0, input int a1);
      int  beat = 0;
      int  k = 0;
      int  a;
      logic eg;
      while (beat < nbeats) begin
         a = first + beat;
         bus.init_req     = 1'b1;
         bus.init_addr    = ADDR_W'(a);
         bus.init_state   = STATE_W'(a);
         bus.init_color   = col_of(a);
         bus.fsm_wr_en    = (k == fsm_k) || (k == fsm_k + 1);
         bus.fsm_wr_addr  = (k == fsm_k) ? ADDR_W'(a0) : ADDR_W'(a1);
         bus.fsm_wr_state = 2'b01;
         @(negedge clk);
         eg = !((k == fsm_k + 1) || (k == fsm_k + 2));
         chk("init_gnt", 32'(bus.init_gnt), 32'(eg));
         if (eg) begin
            exp_wr(a, STATE_W'(a), col_of(a), 1'b1, 1);
            beat++;
         end
         if (k == fsm_k)     exp_wr(a0, 2'b01, '0, 1'b0, 2);
         if (k == fsm_k + 1) exp_wr(a1, 2'b01, '0, 1'b0, 2);
         tick();
         k++;
      end
      bus.init_req  = 1'b0;
      bus.fsm_wr_en = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int beat;
      logic eg_rd;
      for (int i = 0; i < 32; i++) begin
         ram_st[i] = '0; ram_col[i] = '0; sh_st[i] = '0; sh_col[i] = '0;
      end
      rst = 1'b1;
      bus.fsm_wr_en = 1'b0; bus.fsm_wr_addr = '0; bus.fsm_wr_state = '0;
      bus.init_req = 1'b1; bus.init_addr = '0; bus.init_state = '0; bus.init_color = '0;
      bus.rd_req = 1'b0; bus.rd_addr = '0; bus.mem_ready = 1'b1;

      // Reset: outputs quiet, no grant while rst is high even with init_req held.
      repeat (3) begin
         @(negedge clk);
         chk("rst_init_gnt", 32'(bus.init_gnt), 32'(0));
         chk("rst_rd_gnt", 32'(bus.rd_gnt), 32'(0));
         chk("rst_mem_we", 32'(bus.mem_we), 32'(0));
         chk("rst_mem_addr", 32'(bus.mem_addr), 32'(0));
         chk("rst_rd_valid", 32'(bus.rd_valid), 32'(0));
         chk("rst_fifo_ovf", 32'(bus.fifo_ovf), 32'(0));
      end
      tick();
      rst = 1'b0;

      // Plain init burst, 20 beats.
      init_burst(0, 20, -10, 0, 0);

      // Game pulses to 3 then 7 in the middle of an init burst.
      init_burst(0, 6, 1, 3, 7);
      @(negedge clk);
      chk("ovf_after_burst", 32'(bus.fifo_ovf), 32'(0));
      tick();

      // RAM busy: third game write overflows the two-entry buffer.
      bus.mem_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         bus.fsm_wr_en    = 1'b1;
         bus.fsm_wr_addr  = ADDR_W'(10 + k);
         bus.fsm_wr_state = STATE_W'(k + 1);
         @(negedge clk);
         chk("ovf_before_drop", 32'(bus.fifo_ovf), 32'(0));
         tick();
      end
      bus.fsm_wr_en = 1'b0;
      bus.mem_ready = 1'b1;
      @(negedge clk);
      chk("ovf_set", 32'(bus.fifo_ovf), 32'(1));
      exp_wr(10, 2'b01, '0, 1'b0, 1);
      tick();
      @(negedge clk);
      exp_wr(11, 2'b10, '0, 1'b0, 1);
      tick();

      // Init and read held together: read promoted on the 9th cycle.
      bus.rd_req  = 1'b1;
      bus.rd_addr = ADDR_W'(4);
      beat = 0;
      for (int k = 0; k < 11; k++) begin
         bus.init_req   = 1'b1;
         bus.init_addr  = ADDR_W'(20 + beat);
         bus.init_state = STATE_W'(20 + beat);
         bus.init_color = col_of(20 + beat);
         @(negedge clk);
         eg_rd = (k == 8);
         chk("starve_rd_gnt", 32'(bus.rd_gnt), 32'(eg_rd));
         chk("starve_init_gnt", 32'(bus.init_gnt), 32'(!eg_rd));
         if (eg_rd) begin
            exp_rd(4);
         end else begin
            exp_wr(20 + beat, STATE_W'(20 + beat), col_of(20 + beat), 1'b1, 1);
            beat++;
         end
         tick();
         if (k == 8) bus.rd_req = 1'b0;
      end
      bus.init_req = 1'b0;
      @(negedge clk);
      chk("ovf_sticky", 32'(bus.fifo_ovf), 32'(1));
      tick();

      // Game write of addr 5 then read of addr 5 returns the new state.
      bus.fsm_wr_en    = 1'b1;
      bus.fsm_wr_addr  = ADDR_W'(5);
      bus.fsm_wr_state = 2'b11;
      @(negedge clk);
      exp_wr(5, 2'b11, '0, 1'b0, 2);
      tick();
      bus.fsm_wr_en = 1'b0;
      bus.rd_req    = 1'b1;
      bus.rd_addr   = ADDR_W'(5);
      @(negedge clk);
      chk("wr_then_rd_gnt0", 32'(bus.rd_gnt), 32'(0));
      tick();
      @(negedge clk);
      chk("wr_then_rd_gnt1", 32'(bus.rd_gnt), 32'(1));
      exp_rd(5);
      tick();
      bus.rd_req = 1'b0;
      repeat (2) begin
         @(negedge clk);
         tick();
      end

      // Reset right after a read grant discards the read.
      bus.rd_req  = 1'b1;
      bus.rd_addr = ADDR_W'(9);
      @(negedge clk);
      chk("abort_rd_gnt", 32'(bus.rd_gnt), 32'(1));
      tick();
      bus.rd_req = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("abort_rd_valid", 32'(bus.rd_valid), 32'(0));
      chk("abort_ovf_clear", 32'(bus.fifo_ovf), 32'(0));
      chk("abort_mem_we", 32'(bus.mem_we), 32'(0));
      tick();
      repeat (3) tick();
      @(negedge clk);
      chk("wr_queue_drained", 32'(wq.size()), 32'(0));
      chk("rd_queue_drained", 32'(rq.size()), 32'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
